// File: rtl/mult_acc_pkg.sv
// rtl/mult_acc_pkg.sv - shared types and constants for the product accumulator tile
package mult_acc_pkg;

   typedef enum logic [1:0] {
      ACCUM    = 2'd0,
      DRAIN_LO = 2'd1,
      DRAIN_HI = 2'd2
   } state_t;

   localparam int BYTE_W = 8;

   // Counter must hold NUM_TERMS itself while the frame drains.
   function automatic int cnt_w(input int num_terms);
      return $clog2(num_terms + 1);
   endfunction

endpackage

// File: rtl/acc_byte_serializer.sv
// rtl/acc_byte_serializer.sv - drains a frame sum as low byte then high byte over valid/ready
module acc_byte_serializer
   import mult_acc_pkg::*;
#(
   parameter int ACC_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              i_load,
   input  logic [ACC_W-1:0]  i_sum,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_byte,
   output logic              out_valid,
   output logic              busy,
   output logic              o_idle,
   output logic              o_done
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [BYTE_W-1:0] r_byte;
   logic [BYTE_W-1:0] r_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ACCUM;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_done      = 1'b0;
      if (clear) begin
         w_state_nxt = ACCUM;
      end else begin
         case (r_state)
            ACCUM:    if (i_load)    w_state_nxt = DRAIN_LO;
            DRAIN_LO: if (out_ready) w_state_nxt = DRAIN_HI;
            DRAIN_HI: if (out_ready) begin
               w_state_nxt = ACCUM;
               o_done      = 1'b1;
            end
            default:  w_state_nxt = ACCUM;
         endcase
      end
   end

   // The high byte is captured with the low byte so the drain never looks back at the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte <= '0;
         r_hi   <= '0;
      end else if (clear) begin
         r_byte <= '0;
         r_hi   <= '0;
      end else if (r_state == ACCUM && i_load) begin
         r_byte <= i_sum[BYTE_W-1:0];
         r_hi   <= BYTE_W'(i_sum >> BYTE_W);
      end else if (r_state == DRAIN_LO && out_ready) begin
         r_byte <= r_hi;
      end else if (r_state == DRAIN_HI && out_ready) begin
         r_byte <= '0;
      end
   end

   assign out_byte  = r_byte;
   assign out_valid = (r_state == DRAIN_LO) || (r_state == DRAIN_HI);
   assign busy      = out_valid;
   assign o_idle    = (r_state == ACCUM);

endmodule

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - sums NUM_TERMS multiplier products per frame and returns the sum bytewise
module mult_accumulator
   import mult_acc_pkg::*;
#(
   parameter int NUM_TERMS = 4,
   parameter int ACC_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [BYTE_W-1:0] prod_i,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [BYTE_W-1:0] out_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   output logic              busy
);

   localparam int               CNT_W = cnt_w(NUM_TERMS);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_TERMS - 1);

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic [ACC_W:0]   w_sum;
   logic             w_xfer;
   logic             w_last;
   logic             w_done;

   assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - BYTE_W){1'b0}}, prod_i};
   assign w_xfer = prod_valid & prod_ready & ~clear;
   assign w_last = w_xfer & (r_count == LAST);

   // Overflow restarts on the first addend of a frame, otherwise it accumulates the carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_acc      <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_xfer) begin
         r_acc      <= w_sum[ACC_W-1:0];
         r_count    <= r_count + CNT_W'(1);
         r_overflow <= ((r_count != '0) & r_overflow) | w_sum[ACC_W];
      end else if (w_done) begin
         r_acc   <= '0;
         r_count <= '0;
      end
   end

   assign overflow = r_overflow;

   acc_byte_serializer #(
      .ACC_W(ACC_W)
   ) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .i_load    (w_last),
      .i_sum     (w_sum[ACC_W-1:0]),
      .out_ready (out_ready),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .busy      (busy),
      .o_idle    (prod_ready),
      .o_done    (w_done)
   );

endmodule
